lbp_hist: RTL and testbench

Downstream stage of the LBP engine. Snoops the engine's result-write bus (`lbp_valid`/`lbp_addr`/`lbp_data`) in parallel with the LBP result memory and builds a 256-bin histogram of LBP codes for one 128×128 frame. On the rising edge of the engine's `finish`, it streams all 256 bin counts out over a valid/ready port, clearing each bin as it is read. The next frame then starts from zero.

---
 rtl/lbp_pkg.sv | 29 ++
 rtl/lbp_hist_if.sv | 29 ++
 rtl/lbp_hist_bank.sv | 47 ++++
 rtl/lbp_hist.sv | 117 +++++++++++
 tb/tb_lbp_hist.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and border helper for the LBP histogram block.
package lbp_pkg;

   localparam int IMG_W    = 128;
   localparam int COORD_W  = 7;
   localparam int ADDR_W   = 14;
   localparam int NUM_BINS = 256;
   localparam int BIN_W    = 8;
   localparam int TOTAL_W  = 15;

   localparam logic [TOTAL_W-1:0] TOTAL_MAX = TOTAL_W'(IMG_W * IMG_W);
   localparam logic [TOTAL_W-1:0] TOTAL_ONE = TOTAL_W'(1);

   typedef enum logic {
      ACCUM   = 1'b0,
      READOUT = 1'b1
   } lbp_hist_state_t;

   // Address is {row, col}; a pixel on the outer ring of the frame is a border pixel.
   function automatic logic is_border(input logic [ADDR_W-1:0] addr);
      logic [COORD_W-1:0] row;
      logic [COORD_W-1:0] col;
      row = addr[ADDR_W-1:COORD_W];
      col = addr[COORD_W-1:0];
      return (row == '0) || (row == COORD_W'(IMG_W - 1)) ||
             (col == '0) || (col == COORD_W'(IMG_W - 1));
   endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// Result-snoop and histogram-readout bus of lbp_hist; slave is the histogram block.
interface lbp_hist_if #(
   parameter int CNT_W = 15
);
   import lbp_pkg::*;

   logic                 lbp_valid;
   logic [ADDR_W-1:0]    lbp_addr;
   logic [BIN_W-1:0]     lbp_data;
   logic                 finish;
   logic                 hist_valid;
   logic                 hist_ready;
   logic [BIN_W-1:0]     hist_bin;
   logic [CNT_W-1:0]     hist_count;
   logic                 hist_done;
   logic [TOTAL_W-1:0]   hist_total;
   logic                 err_drop;

   modport master (
      output lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
      input  hist_valid, hist_bin, hist_count, hist_done, hist_total, err_drop
   );

   modport slave (
      input  lbp_valid, lbp_addr, lbp_data, finish, hist_ready,
      output hist_valid, hist_bin, hist_count, hist_done, hist_total, err_drop
   );

endinterface

// File: rtl/lbp_hist_bank.sv
// 256-entry bin counter array: saturating increment port, clear port, and a
// look-ahead read returning the value the addressed bin holds after this edge.
module lbp_hist_bank
   import lbp_pkg::*;
#(
   parameter int CNT_W = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_inc_en,
   input  logic [BIN_W-1:0]  i_inc_idx,
   input  logic              i_clr_en,
   input  logic [BIN_W-1:0]  i_clr_idx,
   input  logic [BIN_W-1:0]  i_rd_idx,
   output logic [CNT_W-1:0]  o_rd_next
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] r_bins [NUM_BINS];
   logic [CNT_W-1:0] w_rd_cur;

   // NOTE: the bins must be cleared by reset (a mid-readout abort starts the next
   // frame from zero), so the array is built from flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_BINS; i++) r_bins[i] <= '0;
      end else begin
         if (i_inc_en && (r_bins[i_inc_idx] != CNT_MAX))
            r_bins[i_inc_idx] <= r_bins[i_inc_idx] + CNT_ONE;
         if (i_clr_en)
            r_bins[i_clr_idx] <= '0;
      end
   end

   // NOTE: o_rd_next is assigned a default first so no path can infer a latch.
   always_comb begin
      w_rd_cur  = r_bins[i_rd_idx];
      o_rd_next = w_rd_cur;
      if (i_clr_en && (i_clr_idx == i_rd_idx))
         o_rd_next = '0;
      else if (i_inc_en && (i_inc_idx == i_rd_idx) && (w_rd_cur != CNT_MAX))
         o_rd_next = w_rd_cur + CNT_ONE;
   end

endmodule

// File: rtl/lbp_hist.sv
// LBP code histogram: accumulates one frame, streams 256 bins on finish rising edge.
// Optional macro LBP_HIST_BORDER_SKIP_EN drops pixels on the outer image ring.
module lbp_hist
   import lbp_pkg::*;
#(
   parameter int CNT_W = 15
) (
   input  logic        clk,
   input  logic        reset,
   lbp_hist_if.slave   bus
);

   lbp_hist_state_t     r_state;
   lbp_hist_state_t     w_state_next;
   logic                r_finish_d;
   logic                r_hist_valid;
   logic [BIN_W-1:0]    r_hist_bin;
   logic [CNT_W-1:0]    r_hist_count;
   logic                r_hist_done;
   logic [TOTAL_W-1:0]  r_hist_total;
   logic                r_err_drop;

   logic                w_finish_rise;
   logic                w_border;
   logic                w_inc_en;
   logic                w_xfer;
   logic                w_last;
   logic [BIN_W-1:0]    w_rd_idx;
   logic [CNT_W-1:0]    w_rd_next;

`ifdef LBP_HIST_BORDER_SKIP_EN
   assign w_border = is_border(bus.lbp_addr);
`else
   assign w_border = 1'b0;
`endif

   assign w_finish_rise = bus.finish & ~r_finish_d;
   assign w_inc_en      = bus.lbp_valid & ~w_border & (r_state == ACCUM);
   assign w_xfer        = r_hist_valid & bus.hist_ready;
   assign w_last        = w_xfer & (r_hist_bin == BIN_W'(NUM_BINS - 1));
   // Look ahead to the bin presented next so hist_count can stay a register.
   assign w_rd_idx      = (r_state == READOUT) ? r_hist_bin + BIN_W'(1) : '0;

   lbp_hist_bank #(.CNT_W(CNT_W)) u_bank (
      .clk       (clk),
      .reset     (reset),
      .i_inc_en  (w_inc_en),
      .i_inc_idx (bus.lbp_data),
      .i_clr_en  (w_xfer),
      .i_clr_idx (r_hist_bin),
      .i_rd_idx  (w_rd_idx),
      .o_rd_next (w_rd_next)
   );

   // NOTE: state and datapath registers use non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ACCUM;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ACCUM:   if (w_finish_rise) w_state_next = READOUT;
         READOUT: if (w_last)        w_state_next = ACCUM;
         default: w_state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_finish_d   <= 1'b0;
         r_hist_valid <= 1'b0;
         r_hist_bin   <= '0;
         r_hist_count <= '0;
         r_hist_done  <= 1'b0;
         r_hist_total <= '0;
         r_err_drop   <= 1'b0;
      end else begin
         r_finish_d  <= bus.finish;
         r_hist_done <= w_last;
         if (bus.lbp_valid && !w_border && (r_state == READOUT))
            r_err_drop <= 1'b1;
         case (r_state)
            ACCUM: begin
               if (w_inc_en && (r_hist_total != TOTAL_MAX))
                  r_hist_total <= r_hist_total + TOTAL_ONE;
               if (w_finish_rise) begin
                  r_hist_valid <= 1'b1;
                  r_hist_bin   <= '0;
                  r_hist_count <= w_rd_next;
               end
            end
            READOUT: begin
               if (w_last) begin
                  r_hist_valid <= 1'b0;
                  r_hist_bin   <= '0;
                  r_hist_count <= '0;
                  r_hist_total <= '0;
               end else if (w_xfer) begin
                  r_hist_bin   <= r_hist_bin + BIN_W'(1);
                  r_hist_count <= w_rd_next;
               end
            end
            default: r_hist_valid <= 1'b0;
         endcase
      end
   end

   assign bus.hist_valid = r_hist_valid;
   assign bus.hist_bin   = r_hist_bin;
   assign bus.hist_count = r_hist_count;
   assign bus.hist_done  = r_hist_done;
   assign bus.hist_total = r_hist_total;
   assign bus.err_drop   = r_err_drop;

endmodule

// File: tb/tb_lbp_hist.sv
// Randomised bench for lbp_hist: a default instance and a CNT_W=4 instance share
// stimulus; both are compared against a frame-level histogram model.
module tb_lbp_hist;

   localparam int CNT_W = 15;
   localparam int SAT_W = 4;
   localparam int SAT_MAX = 15;
   localparam int TOT_MAX = 16384;
   localparam int INTERIOR = (5 * 128) + 9;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        lbp_valid = 1'b0;
   logic [13:0] lbp_addr = '0;
   logic [7:0]  lbp_data = '0;
   logic        finish = 1'b0;
   logic        hist_ready = 1'b0;

   always #5 clk = ~clk;

   lbp_hist_if #(.CNT_W(CNT_W)) bus ();
   lbp_hist_if #(.CNT_W(SAT_W)) sbus ();

   assign bus.lbp_valid   = lbp_valid;
   assign bus.lbp_addr    = lbp_addr;
   assign bus.lbp_data    = lbp_data;
   assign bus.finish      = finish;
   assign bus.hist_ready  = hist_ready;
   assign sbus.lbp_valid  = lbp_valid;
   assign sbus.lbp_addr   = lbp_addr;
   assign sbus.lbp_data   = lbp_data;
   assign sbus.finish     = finish;
   assign sbus.hist_ready = hist_ready;

   lbp_hist #(.CNT_W(CNT_W)) u_dut     (.clk(clk), .reset(reset), .bus(bus));
   lbp_hist #(.CNT_W(SAT_W)) u_dut_sat (.clk(clk), .reset(reset), .bus(sbus));

   int n_cmp = 0;
   int n_bad = 0;
   int model_bins [256];
   int model_total;
   int model_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit counted(input int addr);
`ifdef LBP_HIST_BORDER_SKIP_EN
      int row = addr / 128;
      int col = addr % 128;
      return !((row == 0) || (row == 127) || (col == 0) || (col == 127));
`else
      return (addr >= 0);
`endif
   endfunction

   function automatic int sat(input int v);
      return (v > SAT_MAX) ? SAT_MAX : v;
   endfunction

   task automatic clear_model();
      for (int b = 0; b < 256; b++) model_bins[b] = 0;
      model_total = 0;
      model_err   = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one pixel for one edge; lbp_valid is left high for back-to-back use.
   task automatic put_pixel(input int addr, input int code);
      lbp_valid = 1'b1;
      lbp_addr  = 14'(addr);
      lbp_data  = 8'(code);
      if (counted(addr)) begin
         model_bins[code] = model_bins[code] + 1;
         if (model_total < TOT_MAX) model_total = model_total + 1;
      end
      step();
   endtask

   task automatic random_frame(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            lbp_valid = 1'b0;
            step();
         end
         put_pixel(int'($urandom_range(0, 16383)), int'($urandom_range(0, 255)));
      end
      lbp_valid = 1'b0;
   endtask

   task automatic start_readout(input bit edge_pixel, input int code);
      finish = 1'b1;
      if (edge_pixel) put_pixel(INTERIOR, code);
      else            step();
      lbp_valid = 1'b0;
      check("start_valid", bus.hist_valid, 1);
      check("start_bin", bus.hist_bin, 0);
   endtask

   // mode 0: ready always, 1: ready one cycle in three, 2: random ready.
   task automatic readout(input int mode, input int drop_beat, input int abort_beat,
                          input int exp_cycles, input bit spill);
      int idx = 0;
      int cyc = 0;
      bit rdy;
      check("total", bus.hist_total, model_total);
      while ((idx < 256) && (cyc < 2000)) begin
         if (idx == abort_beat) begin
            finish     = 1'b0;
            hist_ready = 1'b0;
            reset      = 1'b1;
            step();
            check("abort_valid", bus.hist_valid, 0);
            check("abort_done", bus.hist_done, 0);
            reset = 1'b0;
            clear_model();
            step();
            check("abort_done2", bus.hist_done, 0);
            check("abort_err", bus.err_drop, 0);
            return;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((cyc % 3) == 2);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         hist_ready = rdy;
         lbp_valid  = (cyc == drop_beat);
         if (cyc == drop_beat) begin
            lbp_addr  = 14'(INTERIOR);
            lbp_data  = 8'($urandom_range(0, 255));
            model_err = 1;
         end
         check("valid", bus.hist_valid, 1);
         check("bin", bus.hist_bin, idx);
         check("count", bus.hist_count, model_bins[idx]);
         check("count4", sbus.hist_count, sat(model_bins[idx]));
         check("done_low", bus.hist_done, 0);
         step();
         if (rdy) begin
            model_bins[idx] = 0;
            idx++;
         end
         cyc++;
      end
      lbp_valid  = 1'b0;
      hist_ready = 1'b0;
      check("beats", idx, 256);
      if (exp_cycles > 0) check("cycles", cyc, exp_cycles);
      check("done", bus.hist_done, 1);
      check("done4", sbus.hist_done, 1);
      check("end_valid", bus.hist_valid, 0);
      check("total_clr", bus.hist_total, 0);
      check("err", bus.err_drop, model_err);
      model_total = 0;
      // ACCUM must already accept a pixel in the hist_done cycle.
      if (spill) put_pixel(INTERIOR, 7);
      else       step();
      lbp_valid = 1'b0;
      check("done_pulse", bus.hist_done, 0);
      check("no_retrigger", bus.hist_valid, 0);
      finish = 1'b0;
      step();
   endtask

   initial begin
      clear_model();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst_valid", bus.hist_valid, 0);
      check("rst_done", bus.hist_done, 0);
      check("rst_bin", bus.hist_bin, 0);
      check("rst_count", bus.hist_count, 0);
      check("rst_total", bus.hist_total, 0);
      check("rst_err", bus.err_drop, 0);

      // All-zero codes over a full frame.
      for (int i = 0; i < 16384; i++) put_pixel(i, 0);
      lbp_valid = 1'b0;
      start_readout(1'b0, 0);
      readout(0, -1, -1, 256, 1'b1);

      // Uniform codes; edge-cycle pixel on code 0 must land in the first beat.
      for (int i = 0; i < 16384; i++) put_pixel(i, i % 256);
      lbp_valid = 1'b0;
      start_readout(1'b1, 0);
      readout(0, -1, -1, 256, 1'b0);

      // Backpressure on random traffic, then an empty frame reads back all zero.
      random_frame(3000);
      start_readout(1'b0, 0);
      readout(1, -1, -1, 768, 1'b0);
      start_readout(1'b0, 0);
      readout(2, -1, -1, 0, 1'b0);

      // Saturation of the CNT_W=4 instance.
      for (int i = 0; i < 20; i++) put_pixel(INTERIOR + i, 8'h55);
      lbp_valid = 1'b0;
      start_readout(1'b0, 0);
      readout(2, -1, -1, 0, 1'b0);

      // Drop during readout, then re-arm with a second frame.
      random_frame(500);
      start_readout(1'b0, 0);
      readout(0, 10, -1, 256, 1'b0);
      check("err_sticky", bus.err_drop, 1);
      for (int i = 0; i < 10; i++) put_pixel(INTERIOR + i, 8'h03);
      lbp_valid = 1'b0;
      start_readout(1'b0, 0);
      readout(0, -1, -1, 256, 1'b0);

      // Reset mid-readout, then a fresh frame.
      random_frame(200);
      start_readout(1'b0, 0);
      readout(0, -1, 100, 0, 1'b0);
      random_frame(50);
      start_readout(1'b0, 0);
      readout(2, -1, -1, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
